// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core-wide widths and word type
package riscv_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

endpackage : riscv_pkg

// File: rtl/en_register_bit.sv
// rtl/en_register_bit.sv - one flop with load enable and async active-low reset
module en_register_bit #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : en_register_bit

// File: rtl/en_register.sv
// rtl/en_register.sv - WIDTH-bit enable register; EN_REGISTER_ASSERT_EN adds checkers
module en_register
    import riscv_pkg::*;
#(
    parameter int               WIDTH       = XLEN,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Per-bit flops so each bit carries its own reset constant.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        en_register_bit #(
            .RESET_VALUE (RESET_VALUE[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (d[i]),
            .q   (q[i])
        );
    end

`ifdef EN_REGISTER_ASSERT_EN
    a_load : assert property (@(posedge clk) disable iff (!rst)
        en |=> (q == $past(d)));

    a_hold : assert property (@(posedge clk) disable iff (!rst)
        !en |=> $stable(q));

    // Reset value check must stay live while rst is low.
    a_reset_value : assert property (@(posedge clk)
        !rst |-> (q == RESET_VALUE));

    a_en_known : assert property (@(posedge clk) disable iff (!rst)
        !$isunknown(en));
`endif

endmodule : en_register

// File: tb/tb_en_register.sv
// tb/tb_en_register.sv - directed and scoreboarded checks of en_register
module tb_en_register;

    localparam logic [63:0] RV64 = 64'h0123456789ABCDEF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [31:0] d32 = '0;
    logic [31:0] q32;
    logic        d1  = 1'b0;
    logic        q1;
    logic [63:0] d64 = '0;
    logic [63:0] q64;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    en_register #(.WIDTH(32), .RESET_VALUE(32'h0)) u_dut32 (
        .clk (clk), .rst (rst), .en (en), .d (d32), .q (q32)
    );

    en_register #(.WIDTH(1)) u_dut1 (
        .clk (clk), .rst (rst), .en (en), .d (d1), .q (q1)
    );

    en_register #(.WIDTH(64), .RESET_VALUE(RV64)) u_dut64 (
        .clk (clk), .rst (rst), .en (en), .d (d64), .q (q64)
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; d32 = 32'hDEADBEEF;
        #1;
        total_cnt++;
        if (q32 !== 32'h0) $display("FAIL reset_async q=%h exp=%h", q32, 32'h0);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total_cnt++;
            if (q32 !== 32'h0) $display("FAIL reset_hold%0d q=%h exp=%h", i, q32, 32'h0);
            else pass_cnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (q32 !== 32'hDEADBEEF) $display("FAIL reset_release_load q=%h exp=%h", q32, 32'hDEADBEEF);
        else pass_cnt++;
        // Pulse reset between edges.
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (q32 !== 32'h0) $display("FAIL reset_pulse q=%h exp=%h", q32, 32'h0);
        else pass_cnt++;
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (q32 !== 32'h0) $display("FAIL reset_after_pulse q=%h exp=%h", q32, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_load();
        en = 1'b1; d32 = 32'h12345678;
        @(negedge clk);
        total_cnt++;
        if (q32 !== 32'h12345678) $display("FAIL load_k q=%h exp=%h", q32, 32'h12345678);
        else pass_cnt++;
        d32 = 32'hCAFEF00D;
        @(negedge clk);
        total_cnt++;
        if (q32 !== 32'hCAFEF00D) $display("FAIL load_k1 q=%h exp=%h", q32, 32'hCAFEF00D);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        en = 1'b1; d32 = 32'hA5A5A5A5;
        @(negedge clk);
        en = 1'b0; d32 = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (q32 !== 32'hA5A5A5A5) $display("FAIL hold%0d q=%h exp=%h", i, q32, 32'hA5A5A5A5);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_priority();
        en = 1'b1; d32 = 32'h00000001;
        @(negedge clk);
        total_cnt++;
        if (q32 !== 32'h00000001) $display("FAIL prio_preload q=%h exp=%h", q32, 32'h1);
        else pass_cnt++;
        d32 = 32'h55555555; rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (q32 !== 32'h0) $display("FAIL prio_reset_wins q=%h exp=%h", q32, 32'h0);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (q32 !== 32'h55555555) $display("FAIL prio_first_load q=%h exp=%h", q32, 32'h55555555);
        else pass_cnt++;
    endtask

    task automatic test_width();
        rst = 1'b0; en = 1'b0;
        #1;
        total_cnt++;
        if (q64 !== RV64) $display("FAIL w64_reset q=%h exp=%h", q64, RV64);
        else pass_cnt++;
        total_cnt++;
        if (q1 !== 1'b0) $display("FAIL w1_reset q=%b exp=%b", q1, 1'b0);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1; en = 1'b1; d64 = '1; d1 = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (q64 !== 64'hFFFFFFFFFFFFFFFF) $display("FAIL w64_ones q=%h exp=%h", q64, 64'hFFFFFFFFFFFFFFFF);
        else pass_cnt++;
        total_cnt++;
        if (q1 !== 1'b1) $display("FAIL w1_one q=%b exp=%b", q1, 1'b1);
        else pass_cnt++;
        en = 1'b0; d1 = 1'b0; d64 = '0;
        @(negedge clk);
        total_cnt++;
        if (q1 !== 1'b1) $display("FAIL w1_hold q=%b exp=%b", q1, 1'b1);
        else pass_cnt++;
        en = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (q1 !== 1'b0) $display("FAIL w1_zero q=%b exp=%b", q1, 1'b0);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] m32;
        logic [63:0] m64;
        m32 = q32;
        m64 = q64;
        for (int c = 0; c < 1000; c++) begin
            rst = ($urandom_range(0, 9) != 0);
            en  = $urandom_range(0, 1) == 1;
            d32 = $urandom;
            d64 = {$urandom, $urandom};
            #1;
            if (!rst) begin
                m32 = 32'h0;
                m64 = RV64;
                total_cnt++;
                if (q32 !== m32 || q64 !== m64)
                    $display("FAIL rand_async c=%0d q32=%h exp=%h q64=%h exp=%h", c, q32, m32, q64, m64);
                else pass_cnt++;
            end else if (en) begin
                m32 = d32;
                m64 = d64;
            end
            @(negedge clk);
            total_cnt++;
            if (q32 !== m32 || q64 !== m64)
                $display("FAIL rand c=%0d q32=%h exp=%h q64=%h exp=%h", c, q32, m32, q64, m64);
            else pass_cnt++;
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load();
        test_hold();
        test_reset_priority();
        test_width();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_en_register
